// File: rtl/event_fifo.sv
// Keyboard/front-panel event FIFO: arbitrated single write per cycle, drop accounting on overflow.
// Optional auto-repeat suppression enabled by defining REPEAT_FILTER_EN.
module event_fifo #(
  parameter int KEY_W  = 8,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [KEY_W-1:0]         keycode,
  input  logic                     key_is_press,
  input  logic                     key_en,
  input  logic                     increase,
  input  logic                     decrease,
  input  logic                     change_menu,
  input  logic                     clear,
  output logic [KEY_W+2:0]         evt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = KEY_W + 2;

  typedef enum logic [1:0] {
    K_RELEASE = 2'b00,
    K_PRESS   = 2'b01,
    K_CTRL    = 2'b10
  } kind_t;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;
  logic [2:0]        r_pend;

  logic              w_key_ok;
  logic [2:0]        w_pend;
  logic [2:0]        w_pend_clr;
  logic              w_pop;
  logic              w_room;
  logic              w_wr_en;
  logic              w_drop;
  logic [ENT_W-1:0]  w_wr_data;
  kind_t             w_key_kind;

`ifdef REPEAT_FILTER_EN
  logic [KEY_W-1:0]  r_held_key;
  logic              r_held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held_key <= '0;
      r_held     <= 1'b0;
    end else if (key_en) begin
      if (key_is_press) begin
        r_held_key <= keycode;
        r_held     <= 1'b1;
      end else if (r_held && (keycode == r_held_key)) begin
        r_held     <= 1'b0;
      end
    end
  end

  assign w_key_ok = key_en && !(key_is_press && r_held && (keycode == r_held_key));
`else
  assign w_key_ok = key_en;
`endif

  // Same-cycle strobes are folded into pending so they can win arbitration immediately.
  always_comb begin
    w_pend     = r_pend | {change_menu, decrease, increase};
    w_pop      = clear && (r_count != '0);
    w_room     = (r_count != CNT_W'(DEPTH)) || w_pop;
    w_key_kind = key_is_press ? K_PRESS : K_RELEASE;
    w_wr_en    = 1'b0;
    w_wr_data  = '0;
    w_pend_clr = '0;
    w_drop     = 1'b0;
    if (w_key_ok) begin
      if (w_room) begin
        w_wr_en   = 1'b1;
        w_wr_data = {w_key_kind, keycode};
      end else begin
        w_drop    = 1'b1;
      end
    end else if (w_room) begin
      if (w_pend[0]) begin
        w_wr_en    = 1'b1;
        w_wr_data  = {K_CTRL, KEY_W'(1)};
        w_pend_clr = 3'b001;
      end else if (w_pend[1]) begin
        w_wr_en    = 1'b1;
        w_wr_data  = {K_CTRL, KEY_W'(2)};
        w_pend_clr = 3'b010;
      end else if (w_pend[2]) begin
        w_wr_en    = 1'b1;
        w_wr_data  = {K_CTRL, KEY_W'(3)};
        w_pend_clr = 3'b100;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_pend       <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_pop);
      r_pend  <= w_pend & ~w_pend_clr;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_data;
  end

  assign evt        = (r_count != '0) ? {1'b1, r_mem[r_rd_ptr]} : '0;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: doc/event_fifo.md
Name: event_fifo

Overview:
- Parametrised successor to the single-slot keyboard event buffer between the key decoder and the processor.
- Queues key press/release events and front-panel control strobes (increase, decrease, change_menu) in a DEPTH-entry FIFO.
- Presents the oldest entry on evt; the processor pops it with a one-cycle clear pulse.
- Adds arbitration of simultaneous sources, drop accounting on overflow, and optional auto-repeat suppression.

Parameters:
KEY_W, 8, keycode width
DEPTH, 8, FIFO entries; power of two, >=2
DROP_W, 8, width of saturating dropped-event counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
keycode  input  KEY_W  key scan code, valid when key_en=1
key_is_press  input  1  1=press, 0=release; qualified by key_en
key_en  input  1  one-cycle key event strobe
increase  input  1  one-cycle control strobe
decrease  input  1  one-cycle control strobe
change_menu  input  1  one-cycle control strobe
clear  input  1  one-cycle pop request from processor
evt  output  KEY_W+3  {valid, kind[1:0], payload[KEY_W-1:0]}; all zero when empty
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky; set when a key event is dropped
drop_count  output  DROP_W  saturating count of dropped key events

Behaviour:
- Reset (reset=0, async): rd/wr pointers=0, count=0, evt=0, overflow=0, drop_count=0, pending bits=0, repeat-filter state cleared. Takes effect immediately, including mid-operation.
- Entry encoding:
  - kind 00: release, payload=keycode.
  - kind 01: press, payload=keycode.
  - kind 10: control; payload zero-extended code: 1=increase, 2=decrease, 3=change_menu.
  - kind 11: unused.
- evt is combinational from mem[rd_ptr] when count!=0, else 0. Write at edge N is visible on evt after edge N (no same-cycle bypass).
- Control strobes set sticky pending bits. A strobe whose pending bit is already set is merged, not queued twice.
- Write arbitration, at most one write per cycle, priority order:
  1. key_en event (after filter).
  2. increase.
  3. decrease.
  4. change_menu.
- A strobe arriving in the same cycle counts as pending for arbitration.
- A control's pending bit clears only on the edge that writes it.
- Full (count==DEPTH):
  - Key event: dropped; overflow<=1; drop_count increments, saturating at all-ones.
  - Controls: stay pending; never dropped.
- Pop: clear=1 with count!=0 advances rd_ptr. clear with count==0 is ignored (no underflow, no state change).
- Simultaneous write and pop: both occur and count is unchanged; legal when full. A pop frees the slot in the same edge, so nothing is dropped.
- Pointers wrap modulo DEPTH. count is the authority for full/empty.
- overflow stays set until reset.

Optional Feature:
REPEAT_FILTER_EN
- Defined: tracks the last accepted press keycode plus a held flag.
  - A press equal to the held key is discarded silently: no write, no drop count.
  - A release of the held key clears the flag; the release is still queued.
  - A press of a different key replaces the held key.
- Undefined: every key_en event is a write candidate and the filter logic is absent.

Test Plan:
- Reset with reset=0, then press 0x15 (key_en for 1 cycle) -> next cycle evt=0x515, count=1. Pulse clear -> evt=0x000, count=0.
- Press 0x15, then release 0x15, then pulse increase -> pops yield 0x515, 0x415, 0x601 in order.
- Same cycle: key_en press 0x1C plus increase plus change_menu -> entries 0x51C, 0x601, 0x603 written on three consecutive edges.
- Fill 8 key presses (distinct codes) then a 9th -> count=8, 9th dropped, overflow=1, drop_count=1.
- Full FIFO: 9th key_en coincident with clear -> count stays 8, no drop, 9th event becomes last entry.
- Press 0x15 three times, then release -> with REPEAT_FILTER_EN: 2 entries (0x515, 0x415); without: 4 entries.
- clear on empty FIFO -> count=0, evt=0.
- Assert reset mid-fill -> all outputs 0 immediately.
